// File: rtl/ofifo_param_if.sv
// Bus bundle for ofifo_param: per-lane writes in, aligned-row pops out,
// plus occupancy and error status.
interface ofifo_param_if #(
  parameter int COL   = 8,
  parameter int BW    = 16,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [COL-1:0]    wr;
  logic [BW*COL-1:0] in;
  logic              rd;
  logic [BW*COL-1:0] out;
  logic              o_rd_valid;
  logic              o_valid;
  logic              o_full;
  logic              o_ready;
  logic              o_almost_full;
  logic [CW-1:0]     o_rows;
  logic [COL-1:0]    o_err_ovf;
  logic              o_err_udf;

  modport master (
    output wr, in, rd,
    input  out, o_rd_valid, o_valid, o_full, o_ready, o_almost_full,
           o_rows, o_err_ovf, o_err_udf
  );

  modport slave (
    input  wr, in, rd,
    output out, o_rd_valid, o_valid, o_full, o_ready, o_almost_full,
           o_rows, o_err_ovf, o_err_udf
  );
endinterface

// File: rtl/ofifo_param.sv
// Output FIFO: COL independent write lanes, each DEPTH deep; a pop takes one
// word from every lane at once and only when every lane holds data.
module ofifo_param #(
  parameter int COL    = 8,
  parameter int BW     = 16,
  parameter int DEPTH  = 16,
  parameter int AF_THR = 12
) (
  input  logic          clk,
  input  logic          reset,
  ofifo_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BW-1:0]     r_mem    [COL][DEPTH];
  logic [AW-1:0]     r_wr_ptr [COL];
  logic [AW-1:0]     r_rd_ptr [COL];
  logic [CW-1:0]     r_cnt    [COL];
  logic [BW*COL-1:0] r_out;
  logic              r_rd_valid;
  logic [COL-1:0]    r_err_ovf;
  logic              r_err_udf;

  logic [CW-1:0]     w_min;
  logic [CW-1:0]     w_max;
  logic [COL-1:0]    w_wr_acc;
  logic              w_pop;
  logic [BW*COL-1:0] w_row;

  // Slowest lane sets row availability, fullest lane sets full/almost-full.
  always_comb begin
    w_min = CW'(DEPTH);
    w_max = '0;
    for (int i = 0; i < COL; i++) begin
      if (r_cnt[i] < w_min) w_min = r_cnt[i];
      if (r_cnt[i] > w_max) w_max = r_cnt[i];
    end
  end

  // Accept decisions use pre-edge counts, so a pop never frees room for a
  // write landing in the same cycle.
  always_comb begin
    w_pop = bus.rd && (w_min != '0);
    w_wr_acc = '0;
    for (int i = 0; i < COL; i++)
      w_wr_acc[i] = bus.wr[i] && (r_cnt[i] != CW'(DEPTH));
  end

  // Head-of-lane words form the row that a pop will register.
  always_comb begin
    w_row = '0;
    for (int i = 0; i < COL; i++)
      w_row[BW*i +: BW] = r_mem[i][r_rd_ptr[i]];
  end

  // Lane storage; contents are not reset, pointers make stale data invisible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < COL; i++)
      if (!reset && w_wr_acc[i]) r_mem[i][r_wr_ptr[i]] <= bus.in[BW*i +: BW];
  end

  // Per-lane pointers, counts and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COL; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_err_ovf <= '0;
    end else begin
      for (int i = 0; i < COL; i++) begin
        if (w_wr_acc[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
        if (w_pop)       r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
        case ({w_wr_acc[i], w_pop})
          2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
          2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
          default: r_cnt[i] <= r_cnt[i];
        endcase
        if (bus.wr[i] && !w_wr_acc[i]) r_err_ovf[i] <= 1'b1;
      end
    end
  end

  // Registered row output, read strobe and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out      <= '0;
      r_rd_valid <= 1'b0;
      r_err_udf  <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) r_out <= w_row;
      if (bus.rd && !w_pop) r_err_udf <= 1'b1;
    end
  end

  assign bus.out           = r_out;
  assign bus.o_rd_valid    = r_rd_valid;
  assign bus.o_valid       = (w_min != '0);
  assign bus.o_full        = (w_max == CW'(DEPTH));
  assign bus.o_ready       = (w_max != CW'(DEPTH));
  assign bus.o_almost_full = (w_max >= CW'(AF_THR));
  assign bus.o_rows        = w_min;
  assign bus.o_err_ovf     = r_err_ovf;
  assign bus.o_err_udf     = r_err_udf;
endmodule

// File: tb/tb_ofifo_param.sv
// Bench for ofifo_param: per-lane word queues model the FIFO; popped rows go
// to a scoreboard that a negedge monitor compares against the DUT output.
module tb_ofifo_param;
  localparam int COL    = 8;
  localparam int BW     = 16;
  localparam int DEPTH  = 16;
  localparam int AF_THR = 12;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ofifo_param_if #(.COL(COL), .BW(BW), .DEPTH(DEPTH)) bus ();

  ofifo_param #(.COL(COL), .BW(BW), .DEPTH(DEPTH), .AF_THR(AF_THR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [BW-1:0]     mq [COL][$];
  logic [BW*COL-1:0] exp_q [$];
  logic [COL-1:0]    m_ovf;
  logic              m_udf;
  logic              m_rdv;
  int                n_vec = 0;
  int                n_err = 0;

  function automatic void check(string name, logic [BW*COL-1:0] act, logic [BW*COL-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [BW*COL-1:0] rep(logic [BW-1:0] v);
    return {COL{v}};
  endfunction

  // monitor: every presented row must be the oldest expected row
  always @(negedge clk) begin
    if (bus.o_rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL row_unexpected: got %h expected none at %0t", bus.out, $time);
      end else begin
        check("row_data", bus.out, exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic [COL-1:0] w, input logic [BW*COL-1:0] d,
                      input logic r, input logic rs);
    int mn, mx;
    logic pop;
    logic [COL-1:0] fullv;
    logic [BW*COL-1:0] row;
    bus.wr = w; bus.in = d; bus.rd = r; reset = rs;
    pop = 1'b0;
    if (rs) begin
      for (int i = 0; i < COL; i++) mq[i].delete();
      m_ovf = '0;
      m_udf = 1'b0;
    end else begin
      mn = DEPTH;
      for (int i = 0; i < COL; i++) begin
        if (mq[i].size() < mn) mn = mq[i].size();
        fullv[i] = (mq[i].size() == DEPTH);
      end
      pop = r && (mn > 0);
      if (r && !pop) m_udf = 1'b1;
      if (pop) begin
        row = '0;
        for (int i = 0; i < COL; i++) row[BW*i +: BW] = mq[i].pop_front();
        exp_q.push_back(row);
      end
      for (int i = 0; i < COL; i++)
        if (w[i]) begin
          if (fullv[i]) m_ovf[i] = 1'b1;
          else mq[i].push_back(d[BW*i +: BW]);
        end
    end
    m_rdv = pop;
    @(posedge clk);
    #1;
    mn = DEPTH; mx = 0;
    for (int i = 0; i < COL; i++) begin
      if (mq[i].size() < mn) mn = mq[i].size();
      if (mq[i].size() > mx) mx = mq[i].size();
    end
    check("o_rows",        BW*COL'(bus.o_rows),  BW*COL'(mn));
    check("o_valid",       BW*COL'(bus.o_valid), BW*COL'(mn > 0));
    check("o_full",        BW*COL'(bus.o_full),  BW*COL'(mx == DEPTH));
    check("o_ready",       BW*COL'(bus.o_ready), BW*COL'(mx != DEPTH));
    check("o_almost_full", BW*COL'(bus.o_almost_full), BW*COL'(mx >= AF_THR));
    check("o_err_ovf",     BW*COL'(bus.o_err_ovf), BW*COL'(m_ovf));
    check("o_err_udf",     BW*COL'(bus.o_err_udf), BW*COL'(m_udf));
    check("o_rd_valid",    BW*COL'(bus.o_rd_valid), BW*COL'(m_rdv));
    if (rs) check("out_after_reset", bus.out, '0);
  endtask

  task automatic do_reset();
    step('0, '0, 1'b0, 1'b1);
  endtask

  logic [BW*COL-1:0] rd_data;
  logic [COL-1:0]    rw;
  logic [BW-1:0]     cnt16;

  initial begin
    bus.wr = '0; bus.in = '0; bus.rd = 1'b0; reset = 1'b1;
    m_ovf = '0; m_udf = 1'b0; m_rdv = 1'b0;
    do_reset();
    do_reset();

    // fill all lanes then drain them back to back
    for (int k = 0; k < DEPTH; k++) step('1, rep(BW'(16'h0100 + k)), 1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);

    // skewed lanes with one pop too many
    do_reset();
    for (int k = 0; k < 2; k++) step('1, rep(BW'(16'h0200 + k)), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(8'h01, rep(BW'(16'h0210 + k)), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step('0, '0, 1'b1, 1'b0);
    check("lane0_count", BW*COL'(mq[0].size()), BW*COL'(3));

    // overflow on lane 3 with a simultaneous ignored pop
    do_reset();
    for (int k = 0; k < DEPTH; k++) step(8'h08, rep(BW'(16'h0300 + k)), 1'b0, 1'b0);
    step(8'h08, rep(16'hDEAD), 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);

    // steady streaming across pointer wrap
    do_reset();
    cnt16 = 16'h0400;
    step('1, rep(cnt16), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      cnt16++;
      step('1, rep(cnt16), 1'b1, 1'b0);
    end

    // full lanes: pop lands, writes dropped
    do_reset();
    for (int k = 0; k < DEPTH; k++) step('1, rep(BW'(16'h0500 + k)), 1'b0, 1'b0);
    step('1, rep(16'hBEEF), 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);

    // reset mid-operation with a pop request
    do_reset();
    for (int k = 0; k < 6; k++) step('1, rep(BW'(16'h0600 + k)), 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < COL; i++) rd_data[BW*i +: BW] = BW'($urandom);
      case ($urandom_range(0, 3))
        0:       rw = COL'($urandom);
        1:       rw = '0;
        default: rw = '1;
      endcase
      step(rw, rd_data, ($urandom_range(0, 2) != 0), ($urandom_range(0, 299) == 0));
    end

    for (int k = 0; k < 3; k++) step('0, '0, 1'b0, 1'b0);
    check("scoreboard_drained", BW*COL'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
